// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and address-phase bundle used by the bus arbiter.
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST encodings
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Address-phase field widths
  localparam int AHB_ADDR_W  = 32;
  localparam int AHB_DATA_W  = 32;
  localparam int AHB_TRANS_W = 2;
  localparam int AHB_SIZE_W  = 3;
  localparam int AHB_BURST_W = 3;
  localparam int AHB_PROT_W  = 4;
  localparam int AHB_APH_W   = AHB_ADDR_W + AHB_TRANS_W + 1 + AHB_SIZE_W
                             + AHB_BURST_W + AHB_PROT_W + 1;

  // Everything a master presents during its address phase
  typedef struct packed {
    logic [AHB_ADDR_W-1:0]  haddr;
    logic [AHB_TRANS_W-1:0] htrans;
    logic                   hwrite;
    logic [AHB_SIZE_W-1:0]  hsize;
    logic [AHB_BURST_W-1:0] hburst;
    logic [AHB_PROT_W-1:0]  hprot;
    logic                   hmastlock;
  } ahb_aph_t;

  // A locked transfer only pins the bus while it is an actual transfer
  function automatic logic aph_locked(input ahb_aph_t aph);
    return aph.hmastlock && (aph.htrans != HTRANS_IDLE);
  endfunction

endpackage

// File: rtl/ahb_rr_pick2.sv
// Two-requester picker: chooses who should own the bus when the
// current owner is not simply keeping it.
module ahb_rr_pick2 #(
  parameter logic PARK = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_srv,
  input  logic       owner,
  input  logic       rr_mode,
  output logic       next_gnt
);

  // Lone requester wins; a tie goes away from the last served master when
  // the bus was parked, otherwise away from the current owner.
  always_comb begin
    next_gnt = PARK;
    case (req)
      2'b01:   next_gnt = 1'b0;
      2'b10:   next_gnt = 1'b1;
      2'b11:   next_gnt = rr_mode ? ~last_srv : ~owner;
      default: next_gnt = PARK;
    endcase
  end

endmodule

// File: rtl/ahblite_bus_arbiter.sv
// Two-master AHB-Lite arbiter placed ahead of the address decoder.
// Master 0 is the core (default park master), master 1 the DMA engine.
module ahblite_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int MAX_HOLD    = 16,
  parameter int PARK_MASTER = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,

  input  logic        M0_HBUSREQ,
  output logic        M0_HGRANT,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [2:0]  M0_HBURST,
  input  logic [3:0]  M0_HPROT,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,

  input  logic        M1_HBUSREQ,
  output logic        M1_HGRANT,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [2:0]  M1_HBURST,
  input  logic [3:0]  M1_HPROT,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,

  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HMASTER
);

  localparam logic       PARK_M    = (PARK_MASTER != 0);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  ahb_aph_t   m0_aph;
  ahb_aph_t   m1_aph;
  ahb_aph_t   sel_aph;
  logic [1:0] req;

  logic       grant_q,    grant_d;
  logic       addr_own_q, addr_own_d;
  logic       data_own_q, data_own_d;
  logic       last_srv_q, last_srv_d;
  logic       parked_q,   parked_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic       other_m;
  logic       locked;
  logic       hold_done;
  logic       keep_owner;
  logic       pick_gnt;
  logic       force_idle;

  assign req = {M1_HBUSREQ, M0_HBUSREQ};

  assign m0_aph = '{haddr: M0_HADDR, htrans: M0_HTRANS, hwrite: M0_HWRITE,
                    hsize: M0_HSIZE, hburst: M0_HBURST, hprot: M0_HPROT,
                    hmastlock: M0_HMASTLOCK};
  assign m1_aph = '{haddr: M1_HADDR, htrans: M1_HTRANS, hwrite: M1_HWRITE,
                    hsize: M1_HSIZE, hburst: M1_HBURST, hprot: M1_HPROT,
                    hmastlock: M1_HMASTLOCK};

  // Address-phase mux follows the address owner; locking is judged on the
  // owner's raw signals, before any forced IDLE.
  always_comb begin
    sel_aph    = addr_own_q ? m1_aph : m0_aph;
    locked     = aph_locked(sel_aph);
    other_m    = ~grant_q;
    hold_done  = (hold_cnt_q >= HOLD_LAST);
    // Owner keeps the bus while it requests, unless a contender has waited
    // out the hold window or both arrived on a parked bus (round-robin).
    keep_owner = req[grant_q] && (!req[other_m] || (!parked_q && !hold_done));
    // An owner that lost its grant, or a non-park owner that stopped
    // requesting, must not launch a transfer in its remaining address phase.
    force_idle = (grant_q != addr_own_q) || (!req[addr_own_q] && (addr_own_q != PARK_M));
  end

  ahb_rr_pick2 #(
    .PARK (PARK_M)
  ) u_pick (
    .req      (req),
    .last_srv (last_srv_q),
    .owner    (grant_q),
    .rr_mode  (parked_q),
    .next_gnt (pick_gnt)
  );

  // Next-state for grant, ownership pipeline and fairness counter; nothing
  // moves during wait states and a locked owner freezes the arbitration.
  always_comb begin
    grant_d    = grant_q;
    addr_own_d = addr_own_q;
    data_own_d = data_own_q;
    last_srv_d = last_srv_q;
    parked_d   = parked_q;
    hold_cnt_d = hold_cnt_q;
    if (HREADY) begin
      addr_own_d = grant_q;
      data_own_d = addr_own_q;
      if (!locked) begin
        grant_d  = keep_owner ? grant_q : pick_gnt;
        parked_d = (req == 2'b00);
        if (req[grant_d]) begin
          last_srv_d = grant_d;
        end
        if (grant_d != grant_q) begin
          hold_cnt_d = 8'd0;
        end else if (req[other_m] && !hold_done) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
    end
  end

  // Arbiter state registers with asynchronous return to the park master
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q    <= PARK_M;
      addr_own_q <= PARK_M;
      data_own_q <= PARK_M;
      last_srv_q <= PARK_M;
      parked_q   <= 1'b1;
      hold_cnt_q <= 8'd0;
    end else begin
      grant_q    <= grant_d;
      addr_own_q <= addr_own_d;
      data_own_q <= data_own_d;
      last_srv_q <= last_srv_d;
      parked_q   <= parked_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign M0_HGRANT = ~grant_q;
  assign M1_HGRANT = grant_q;
  assign HMASTER   = addr_own_q;

  assign HADDR     = sel_aph.haddr;
  assign HTRANS    = force_idle ? HTRANS_IDLE : sel_aph.htrans;
  assign HWRITE    = sel_aph.hwrite;
  assign HSIZE     = sel_aph.hsize;
  assign HBURST    = sel_aph.hburst;
  assign HPROT     = sel_aph.hprot;
  assign HMASTLOCK = sel_aph.hmastlock;
  assign HWDATA    = data_own_q ? M1_HWDATA : M0_HWDATA;

endmodule

// File: doc/ahblite_bus_arbiter.md
# ahblite_bus_arbiter

- Two-master AHB-Lite arbiter sitting upstream of the address decoder.
- Shares the single system bus between master 0 (Cortex-M core, default/park master) and master 1 (ACC/DMA engine).
- Uses request/grant handshaking, round-robin arbitration, lock and burst holding, and a fairness hold limit.
- Multiplexes address-phase signals by address owner and HWDATA by data-phase owner.

## Interface
Parameters:
- MAX_HOLD, 16: maximum consecutive HREADY-qualified cycles a master keeps the grant while another requests; unlocked only; range 2..255.
- PARK_MASTER, 0: master granted when neither requests, and after reset.

Ports:
- HCLK  in  1  bus clock.
- HRESET  in  1  asynchronous, active-high reset.
- Mx_HBUSREQ  in  1  bus request from master x (x = 0, 1).
- Mx_HGRANT  out  1  registered grant to master x.
- Mx_HADDR  in  32  address from master x.
- Mx_HTRANS  in  2  transfer type from master x.
- Mx_HWRITE  in  1  write flag from master x.
- Mx_HSIZE  in  3  transfer size from master x.
- Mx_HBURST  in  3  burst type from master x.
- Mx_HPROT  in  4  protection from master x.
- Mx_HMASTLOCK  in  1  locked-transfer flag from master x.
- Mx_HWDATA  in  32  write data from master x.
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK  out  32/2/1/3/3/4/1  muxed address phase to decoder/slaves.
- HWDATA  out  32  muxed write data.
- HREADY  in  1  bus-wide ready, returned from the slave mux (also fanned to masters externally).
- HMASTER  out  1  current address-phase owner.

## Operation
- State registers:
  - grant_q: granted master.
  - addr_own: address-phase owner; drives HMASTER.
  - data_own: data-phase owner.
  - hold_cnt: 8-bit counter.
  - last_srv: round-robin pointer.
- Address mux: all address-phase outputs come from master addr_own (combinational).
- Data mux: HWDATA comes from master data_own.
- Arbitration is evaluated only in cycles with HREADY=1.
- The grant is frozen while addr_own drives HMASTLOCK=1 with HTRANS≠IDLE. In that case, hold_cnt does not advance.
- Otherwise:
  - Owner keeps requesting and the other does not: grant_q is unchanged.
  - Both request: the owner keeps the grant until hold_cnt reaches MAX_HOLD-1. The grant then passes to the other master.
  - Owner releases its request: grant goes to the other requester, else to PARK_MASTER.
  - Neither requests: grant goes to PARK_MASTER.
- hold_cnt:
  - Clears on every grant change.
  - Increments on HREADY=1 cycles while the other master requests.
  - Saturates at MAX_HOLD-1.
- Round-robin tie-break: if both requesters arrive while the park master holds no request, the master ≠ last_srv wins.
- Non-granted address owner: if the master's grant is removed while it is still addr_own, the arbiter forces HTRANS=IDLE for that master's remaining address phase. A granted master that does not request also appears as IDLE via the same rule, unless it is the park master.
- Slave error responses (HRESP) are not inspected. Ownership moves only with HREADY.

## Timing
Reset values:
- grant_q = addr_own = data_own = PARK_MASTER.
- HGRANT: PARK_MASTER's HGRANT=1, the other 0.
- HMASTER = PARK_MASTER.
- hold_cnt = 0, last_srv = PARK_MASTER.
- Bus outputs follow the park master's inputs.

Cycle relationships:
- Mx_HGRANT is registered: a request sampled at edge N with HREADY=1 gives HGRANT at N+1.
- addr_own <= grant_q on edges with HREADY=1. The new master's address therefore appears on the bus one HREADY cycle after its HGRANT rises.
- data_own <= addr_own on edges with HREADY=1.
- HREADY=0 freezes grant_q, addr_own, data_own and hold_cnt. Wait states never change owners.

Edge cases:
- Simultaneous release and new request: the handover completes in the same edge.
- Reset asserted mid-burst: all state returns to reset values immediately and asynchronously. No transfer is completed.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HBURST encodings.
  - Address-phase struct width constants.
- One sub-module is natural: ahb_rr_pick2. It is a combinational two-requester round-robin picker with inputs req[1:0], last_srv and owner, and output next grant.

## Test plan
- Reset, no requests → HGRANT0=1, HMASTER=0. M0 NONSEQ write 0x2000_0004 appears on HADDR; its HWDATA passes one HREADY cycle later.
- M1 requests while M0 idle → M1_HGRANT=1 next edge. HMASTER=1 after the next HREADY edge. M1 read of 0x4000_0010 is visible on HADDR.
- Both request continuously, MAX_HOLD=4, HREADY=1 → grant alternates every 4 cycles.
- M1 sets HMASTLOCK during a 4-beat INCR4 while M0 requests → no handover until M1 drops lock/request. The count stays 0 throughout.
- Handover with HREADY held low 3 cycles during M0's last data phase → HWDATA stays from M0 until HREADY rises. data_own switches only on that edge.
- Assert HRESET mid M1 burst → HMASTER=0 and HGRANT0=1 immediately. Outputs track M0 inputs.
